// File: rtl/alu_pkg.sv
// Shared ALU definitions for the sequential 8x8 multiplier controller.
//   - Width constants for operands, multiplier slice and result.
//   - 3-bit state encodings and the controller state enum built from them.
//   - Left-shift amounts that place each partial product in the result.
package alu_pkg;

  localparam int OP_W    = 8;
  localparam int SLICE_W = 4;
  localparam int RES_W   = 16;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_P0   = 3'd1;
  localparam logic [2:0] ST_P1   = 3'd2;
  localparam logic [2:0] ST_P2   = 3'd3;
  localparam logic [2:0] ST_P3   = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_P0   = ST_P0,
    S_P1   = ST_P1,
    S_P2   = ST_P2,
    S_P3   = ST_P3,
    S_DONE = ST_DONE
  } state_e;

  // Partial product k is weighted by 2**SH_Pk in the final sum.
  localparam logic [3:0] SH_P0 = 4'd0;
  localparam logic [3:0] SH_P1 = 4'd4;
  localparam logic [3:0] SH_P2 = 4'd4;
  localparam logic [3:0] SH_P3 = 4'd8;

endpackage

// File: rtl/multiplier_4bit.sv
// Combinational unsigned 4x4 multiplier.
//   i_op1  in  4  multiplicand nibble
//   i_op2  in  4  multiplier nibble
//   o_mult out 8  unsigned product
module multiplier_4bit (
  input  logic [3:0] i_op1,
  input  logic [3:0] i_op2,
  output logic [7:0] o_mult
);

  assign o_mult = 8'(i_op1) * 8'(i_op2);

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Sequential unsigned 8x8 multiplier built around one 4x4 multiplier.
// Four partial products (lo*lo, lo*hi, hi*lo, hi*hi) are summed into a
// 16-bit accumulator over four cycles; the result is registered on entry
// to DONE and held until the next DONE or reset.
//
// Handshake: i_start is a request that is taken only while the FSM is in
// IDLE (o_busy low). A request seen while o_busy is high, including the
// DONE cycle, is dropped, not queued. Operands are sampled only on the
// accepting edge. o_done pulses for the single DONE cycle with o_mult valid.
//
//   i_clk    in  1   rising-edge clock
//   i_rst    in  1   synchronous active-high reset
//   i_start  in  1   request, taken only in IDLE
//   i_op1    in  8   multiplicand
//   i_op2    in  8   multiplier
//   o_busy   out 1   high in P0..P3 and DONE
//   o_done   out 1   high exactly while in DONE
//   o_mult   out 16  registered product
//   o_state  out 3   current FSM state (debug visibility)
module mult8_seq_ctrl
  import alu_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [OP_W-1:0]  i_op1,
  input  logic [OP_W-1:0]  i_op2,
  output logic             o_busy,
  output logic             o_done,
  output logic [RES_W-1:0] o_mult,
  output logic [2:0]       o_state
);

  state_e             state_q, state_d;
  logic [OP_W-1:0]    a_q, b_q;
  logic [RES_W-1:0]   acc_q;
  logic [RES_W-1:0]   mult_q;

  logic [SLICE_W-1:0]   mul_a, mul_b;
  logic [2*SLICE_W-1:0] pp;
  logic [3:0]           pp_shift;
  logic [RES_W-1:0]     acc_term;
  logic [RES_W-1:0]     acc_sum;
  logic                 load_ops;
  logic                 acc_en;
  logic                 res_en;

  // The only multiplier in the datapath; the nibble mux time-shares it.
  multiplier_4bit u_mul (
    .i_op1  (mul_a),
    .i_op2  (mul_b),
    .o_mult (pp)
  );

  always_comb begin
    state_d  = state_q;
    mul_a    = '0;
    mul_b    = '0;
    pp_shift = SH_P0;
    load_ops = 1'b0;
    acc_en   = 1'b0;
    res_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d  = S_P0;
          load_ops = 1'b1;
        end
      end
      S_P0: begin
        mul_a    = a_q[3:0];
        mul_b    = b_q[3:0];
        pp_shift = SH_P0;
        acc_en   = 1'b1;
        state_d  = S_P1;
      end
      S_P1: begin
        mul_a    = a_q[3:0];
        mul_b    = b_q[7:4];
        pp_shift = SH_P1;
        acc_en   = 1'b1;
        state_d  = S_P2;
      end
      S_P2: begin
        mul_a    = a_q[7:4];
        mul_b    = b_q[3:0];
        pp_shift = SH_P2;
        acc_en   = 1'b1;
        state_d  = S_P3;
      end
      S_P3: begin
        mul_a    = a_q[7:4];
        mul_b    = b_q[7:4];
        pp_shift = SH_P3;
        acc_en   = 1'b1;
        res_en   = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign acc_term = RES_W'(pp) << pp_shift;
  // 255*255 fits in 16 bits, so the sum never wraps.
  assign acc_sum  = acc_q + acc_term;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      mult_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_ops) begin
        a_q   <= i_op1;
        b_q   <= i_op2;
        acc_q <= '0;
      end
      if (acc_en) acc_q <= acc_sum;
      // Final sum includes the P3 term being added on this same edge.
      if (res_en) mult_q <= acc_sum;
    end
  end

  assign o_busy  = (state_q != S_IDLE);
  assign o_done  = (state_q == S_DONE);
  assign o_mult  = mult_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
module tb_mult8_seq_ctrl;
  import alu_pkg::*;

  logic        clk;
  logic        i_rst;
  logic        i_start;
  logic [7:0]  i_op1;
  logic [7:0]  i_op2;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_mult;
  logic [2:0]  o_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];
  logic [15:0] model_mult = 16'h0;
  bit          mon_en = 1'b0;

  typedef struct {
    logic [7:0]  op1;
    logic [7:0]  op2;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[14];

  mult8_seq_ctrl dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_op1   (i_op1),
    .i_op2   (i_op2),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_mult  (o_mult),
    .o_state (o_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(posedge clk) begin
    if (i_rst) begin
      model_mult = 16'h0;
      exp_q.delete();
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (o_done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done with o_mult=%0d, expected no done", o_mult);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          chk("product", 32'(o_mult), 32'(e));
          model_mult = e;
        end
      end else begin
        chk("mult_hold", 32'(o_mult), 32'(model_mult));
      end
    end
  end

  // ---------------- drivers ----------------
  // One accepted operation: start in IDLE, scramble operands after the
  // accepting edge, then expect busy for five cycles with done in the fifth.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    @(negedge clk);
    chk("idle_before_start", 32'(o_busy), 32'd0);
    i_start = 1'b1;
    i_op1   = a;
    i_op2   = b;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_op1   = 8'($urandom_range(0, 255));
    i_op2   = 8'($urandom_range(0, 255));
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("busy_in_flight", 32'(o_busy), 32'd1);
      chk("done_timing", 32'(o_done), (k == 5) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("idle_busy", 32'(o_busy), 32'd0);
      chk("idle_done", 32'(o_done), 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vecs[0]  = '{8'd255, 8'd255, 16'd65025};
    vecs[1]  = '{8'd0,   8'd0,   16'd0};
    vecs[2]  = '{8'd0,   8'd255, 16'd0};
    vecs[3]  = '{8'd255, 8'd0,   16'd0};
    vecs[4]  = '{8'd1,   8'd1,   16'd1};
    vecs[5]  = '{8'h12,  8'h34,  16'h03A8};
    vecs[6]  = '{8'd15,  8'd15,  16'd225};
    vecs[7]  = '{8'd16,  8'd16,  16'd256};
    vecs[8]  = '{8'hF0,  8'h0F,  16'h0E10};
    vecs[9]  = '{8'h0F,  8'hF0,  16'h0E10};
    vecs[10] = '{8'd128, 8'd2,   16'd256};
    vecs[11] = '{8'hAB,  8'hCD,  16'h88EF};
    vecs[12] = '{8'd7,   8'd9,   16'd63};
    vecs[13] = '{8'd3,   8'd5,   16'd15};

    i_rst   = 1'b1;
    i_start = 1'b0;
    i_op1   = 8'h00;
    i_op2   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    @(negedge clk);
    chk("reset_busy",  32'(o_busy),  32'd0);
    chk("reset_done",  32'(o_done),  32'd0);
    chk("reset_mult",  32'(o_mult),  32'd0);
    chk("reset_state", 32'(o_state), 32'(ST_IDLE));
    mon_en = 1'b1;
    idle_cycles(2);

    // Table vectors, back-to-back.
    for (int i = 0; i < 14; i++) run_op(vecs[i].op1, vecs[i].op2, vecs[i].exp);
    // Result must stay put across idle cycles (monitor compares every cycle).
    idle_cycles(3);

    // Continuous start: second accept happens in the IDLE cycle after DONE.
    @(negedge clk);
    i_start = 1'b1;
    i_op1   = 8'd3;
    i_op2   = 8'd5;
    exp_q.push_back(16'd15);
    exp_q.push_back(16'd15);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("cont_busy", 32'(o_busy), (k == 6 || k == 12) ? 32'd0 : 32'd1);
      chk("cont_done", 32'(o_done), (k == 5 || k == 11) ? 32'd1 : 32'd0);
      if (k == 7) i_start = 1'b0;
    end
    idle_cycles(2);

    // Reset mid-operation: discarded result, no done pulse.
    run_op(8'd10, 8'd10, 16'd100);
    @(negedge clk);
    i_start = 1'b1;
    i_op1   = 8'd200;
    i_op2   = 8'd100;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    @(negedge clk);
    chk("midrst_busy_p0", 32'(o_busy), 32'd1);
    @(negedge clk);
    i_rst   = 1'b1;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_rst   = 1'b0;
    i_start = 1'b0;
    @(negedge clk);
    chk("midrst_state", 32'(o_state), 32'(ST_IDLE));
    chk("midrst_busy",  32'(o_busy),  32'd0);
    chk("midrst_done",  32'(o_done),  32'd0);
    chk("midrst_mult",  32'(o_mult),  32'd0);
    idle_cycles(6);
    run_op(8'd7, 8'd9, 16'd63);

    // Random back-to-back operands against the golden product.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(ra, rb, 16'(ra) * 16'(rb));
    end
    idle_cycles(2);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
